// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu run/halt sequencer: state encoding and defaults.
// Purely declarative; no logic, no latency, no flow control.
package cpu_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int unsigned DEF_CYCLES_LIMIT = 100000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CONFIRM = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RESET) || (s == ST_RUN) || (s == ST_CONFIRM);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// One-edge update latency; o_cnt_inc is the combinational post-increment value.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_inc
);

    logic [W-1:0] r_cnt;

    assign o_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + W'(1);
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_cnt_inc;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the cpu core: reset hold, run-cycle count, debounced halt, timeout.
// All outputs registered from the next state (change on the state edge); start ignored while busy.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned CYCLES_LIMIT = DEF_CYCLES_LIMIT,
    parameter int unsigned HALT_CONFIRM = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cpu_hlt,
    input  logic [15:0]      cpu_pc,
    output logic             cpu_rst_n,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles,
    output logic [15:0]      final_pc
);

    localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [3:0]       CFM_LAST = 4'(HALT_CONFIRM - 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYCLES_LIMIT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_rst_cnt;
    logic [7:0]       w_rst_cnt_nxt;
    logic [3:0]       r_cfm_cnt;
    logic [3:0]       w_cfm_cnt_nxt;
    logic             w_cyc_clr;
    logic             w_cyc_en;
    logic             w_limit;
    logic             w_pc_latch;
    logic [CNT_W-1:0] w_cyc_inc;
    logic             r_cpu_rst_n;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic [15:0]      r_final_pc;

    sat_counter #(
        .W(CNT_W)
    ) u_cycles (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cyc_clr),
        .i_en      (w_cyc_en),
        .o_cnt     (cycles),
        .o_cnt_inc (w_cyc_inc)
    );

    // Greater-or-equal keeps a run that crossed the limit inside CONFIRM from running forever.
    assign w_limit = (w_cyc_inc >= LIMIT);

    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_cfm_cnt_nxt = r_cfm_cnt;
        w_cyc_clr     = 1'b0;
        w_cyc_en      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    w_state_nxt   = ST_RESET;
                    w_rst_cnt_nxt = '0;
                    w_cfm_cnt_nxt = '0;
                    w_cyc_clr     = 1'b1;
                end
            end
            ST_RESET: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 8'd1;
                end
            end
            ST_RUN: begin
                w_cyc_en = 1'b1;
                if (cpu_hlt) begin
                    if (HALT_CONFIRM == 1) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt   = ST_CONFIRM;
                        w_cfm_cnt_nxt = 4'd1;
                    end
                end else if (w_limit) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            ST_CONFIRM: begin
                w_cyc_en = 1'b1;
                if (!cpu_hlt) begin
                    w_cfm_cnt_nxt = '0;
                    w_state_nxt   = w_limit ? ST_TIMEOUT : ST_RUN;
                end else if (r_cfm_cnt == CFM_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cfm_cnt_nxt = r_cfm_cnt + 4'd1;
                    if (w_limit) begin
                        w_state_nxt = ST_TIMEOUT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pc_latch = is_busy(r_state) &&
                        ((w_state_nxt == ST_DONE) || (w_state_nxt == ST_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rst_cnt   <= '0;
            r_cfm_cnt   <= '0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_final_pc  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_cfm_cnt   <= w_cfm_cnt_nxt;
            // Core stays released in DONE so its state can be inspected.
            r_cpu_rst_n <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_CONFIRM) ||
                           (w_state_nxt == ST_DONE);
            r_busy      <= is_busy(w_state_nxt);
            r_done      <= (w_state_nxt == ST_DONE);
            r_timeout   <= (w_state_nxt == ST_TIMEOUT);
            if (w_pc_latch) begin
                r_final_pc <= cpu_pc;
            end
        end
    end

    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign final_pc  = r_final_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: two instances (default limit, limit=20) checked each cycle
// against a count-based behavioural model plus hand-computed end-of-run values.
module tb_cpu_run_ctrl;

    localparam int RC  = 2;
    localparam int HC  = 2;
    localparam longint LIM0 = 100000;
    localparam longint LIM1 = 20;

    logic        clk = 1'b0;
    logic        rst_i   [2];
    logic        start_i [2];
    logic        hlt_i   [2];
    logic [15:0] pc_i    [2];

    logic        d0_rst_n, d0_busy, d0_done, d0_to;
    logic [31:0] d0_cyc;
    logic [15:0] d0_fpc;
    logic        d1_rst_n, d1_busy, d1_done, d1_to;
    logic [31:0] d1_cyc;
    logic [15:0] d1_fpc;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl u_dut0 (
        .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .cpu_hlt(hlt_i[0]), .cpu_pc(pc_i[0]),
        .cpu_rst_n(d0_rst_n), .busy(d0_busy), .done(d0_done), .timeout(d0_to),
        .cycles(d0_cyc), .final_pc(d0_fpc)
    );

    cpu_run_ctrl #(.CYCLES_LIMIT(20)) u_dut1 (
        .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .cpu_hlt(hlt_i[1]), .cpu_pc(pc_i[1]),
        .cpu_rst_n(d1_rst_n), .busy(d1_busy), .done(d1_done), .timeout(d1_to),
        .cycles(d1_cyc), .final_pc(d1_fpc)
    );

    // Model: a run is "reset edges left" followed by "released, counting"; a halt streak
    // of HC sampled edges ends it, otherwise reaching the limit ends it.
    typedef struct {
        bit          active;
        int          rst_left;
        bit          released;
        int          streak;
        longint      cycles;
        bit          done;
        bit          tout;
        logic [15:0] fpc;
    } mdl_t;

    mdl_t   mdl [2];
    longint lim [2];

    task automatic model_step(input int k);
        if (rst_i[k]) begin
            mdl[k].active = 0; mdl[k].rst_left = 0; mdl[k].released = 0; mdl[k].streak = 0;
            mdl[k].cycles = 0; mdl[k].done = 0; mdl[k].tout = 0; mdl[k].fpc = '0;
        end else if (!mdl[k].active) begin
            if (start_i[k]) begin
                mdl[k].active = 1; mdl[k].rst_left = RC; mdl[k].released = 0;
                mdl[k].streak = 0; mdl[k].cycles = 0; mdl[k].done = 0; mdl[k].tout = 0;
            end
        end else if (mdl[k].rst_left > 0) begin
            mdl[k].rst_left--;
            if (mdl[k].rst_left == 0) mdl[k].released = 1;
        end else begin
            if (mdl[k].cycles < 64'hFFFF_FFFF) mdl[k].cycles++;
            mdl[k].streak = hlt_i[k] ? mdl[k].streak + 1 : 0;
            if (mdl[k].streak >= HC) begin
                mdl[k].done = 1; mdl[k].active = 0; mdl[k].fpc = pc_i[k];
            end else if (mdl[k].cycles >= lim[k]) begin
                mdl[k].tout = 1; mdl[k].active = 0; mdl[k].released = 0; mdl[k].fpc = pc_i[k];
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp_dut(input int k, input logic rn, input logic b, input logic d,
                           input logic t, input logic [31:0] c, input logic [15:0] f);
        chk($sformatf("dut%0d.cpu_rst_n", k), {63'd0, rn}, {63'd0, mdl[k].released});
        chk($sformatf("dut%0d.busy", k), {63'd0, b}, {63'd0, mdl[k].active});
        chk($sformatf("dut%0d.done", k), {63'd0, d}, {63'd0, mdl[k].done});
        chk($sformatf("dut%0d.timeout", k), {63'd0, t}, {63'd0, mdl[k].tout});
        chk($sformatf("dut%0d.cycles", k), {32'd0, c}, mdl[k].cycles);
        chk($sformatf("dut%0d.final_pc", k), {48'd0, f}, {48'd0, mdl[k].fpc});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, d0_rst_n, d0_busy, d0_done, d0_to, d0_cyc, d0_fpc);
            cmp_dut(1, d1_rst_n, d1_busy, d1_done, d1_to, d1_cyc, d1_fpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core stand-in: hlt held from cycle count a (a<0: never), plus a one-cycle pulse at g.
    task automatic set_hlt(input int k, input int a, input int g);
        bit run;
        run = mdl[k].active && mdl[k].released;
        hlt_i[k] = run && ((a >= 0 && mdl[k].cycles >= a) || (mdl[k].cycles == g));
    endtask

    function automatic bit ended(input int k);
        return (k == 0) ? (d0_done | d0_to) : (d1_done | d1_to);
    endfunction

    task automatic pulse_start(input int k);
        start_i[k] = 1'b1;
        tick();
        start_i[k] = 1'b0;
    endtask

    task automatic run_to_end(input int k, input int a, input int g, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            set_hlt(k, a, g);
            tick();
            if (ended(k)) begin
                ok = 1;
                break;
            end
        end
        hlt_i[k] = 1'b0;
        chk($sformatf("dut%0d.run_ends_in_budget", k), {63'd0, ok}, 64'd1);
    endtask

    initial begin
        int n;
        bit ok;
        lim[0] = LIM0;
        lim[1] = LIM1;
        for (int k = 0; k < 2; k++) begin
            rst_i[k] = 1'b1; start_i[k] = 1'b0; hlt_i[k] = 1'b0; pc_i[k] = '0;
        end
        tick();
        tick();
        chk_en = 1'b1;
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;

        // 1: idle with start low
        for (int i = 0; i < 5; i++) tick();
        chk("idle.cpu_rst_n", {63'd0, d0_rst_n}, 64'd0);
        chk("idle.busy", {63'd0, d0_busy}, 64'd0);
        chk("idle.cycles", {32'd0, d0_cyc}, 64'd0);
        chk("idle.done_timeout", {62'd0, d0_done, d0_to}, 64'd0);

        // 2: halt at 10, confirmed two edges later
        pc_i[0] = 16'h0042;
        pulse_start(0);
        chk("t2.busy_after_start", {63'd0, d0_busy}, 64'd1);
        n = 0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (d0_rst_n) begin
                ok = 1;
                break;
            end
        end
        chk("t2.rst_hold_edges", {32'd0, 32'(n)}, 64'd2);
        chk("t2.released", {63'd0, ok}, 64'd1);
        run_to_end(0, 10, -1, 50);
        chk("t2.cycles", {32'd0, d0_cyc}, 64'd12);
        chk("t2.final_pc", {48'd0, d0_fpc}, 64'h42);
        chk("t2.done", {63'd0, d0_done}, 64'd1);
        chk("t2.busy", {63'd0, d0_busy}, 64'd0);
        chk("t2.cpu_rst_n_kept", {63'd0, d0_rst_n}, 64'd1);

        // 3: start from DONE clears done on the same edge; glitch at 5 rejected
        pc_i[0] = 16'h0123;
        pulse_start(0);
        chk("t3.done_cleared", {63'd0, d0_done}, 64'd0);
        chk("t3.cpu_rst_n_low", {63'd0, d0_rst_n}, 64'd0);
        run_to_end(0, 30, 5, 100);
        chk("t3.cycles", {32'd0, d0_cyc}, 64'd32);
        chk("t3.done", {63'd0, d0_done}, 64'd1);
        chk("t3.final_pc", {48'd0, d0_fpc}, 64'h123);

        // 4: limit 20, no halt
        pc_i[1] = 16'h0777;
        pulse_start(1);
        run_to_end(1, -1, -1, 60);
        chk("t4.cycles", {32'd0, d1_cyc}, 64'd20);
        chk("t4.timeout", {63'd0, d1_to}, 64'd1);
        chk("t4.done", {63'd0, d1_done}, 64'd0);
        chk("t4.cpu_rst_n", {63'd0, d1_rst_n}, 64'd0);
        chk("t4.final_pc", {48'd0, d1_fpc}, 64'h777);

        // 5: halt confirm completes on the limit edge
        pc_i[1] = 16'h0555;
        pulse_start(1);
        chk("t5.timeout_cleared", {63'd0, d1_to}, 64'd0);
        run_to_end(1, 18, -1, 60);
        chk("t5.done", {63'd0, d1_done}, 64'd1);
        chk("t5.timeout", {63'd0, d1_to}, 64'd0);
        chk("t5.cycles", {32'd0, d1_cyc}, 64'd20);

        // 6: reset mid-run at cycles==7
        pulse_start(0);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (d0_cyc == 32'd7) begin
                ok = 1;
                break;
            end
        end
        chk("t6.reached_7", {63'd0, ok}, 64'd1);
        rst_i[0] = 1'b1;
        tick();
        rst_i[0] = 1'b0;
        chk("t6.cycles", {32'd0, d0_cyc}, 64'd0);
        chk("t6.cpu_rst_n", {63'd0, d0_rst_n}, 64'd0);
        chk("t6.busy", {63'd0, d0_busy}, 64'd0);
        chk("t6.done", {63'd0, d0_done}, 64'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt sequencer placed between the top level and the single-cycle `cpu` core. On `start` it holds the core in reset for a fixed number of cycles, then releases it. While the core runs it counts cycles and confirms the `hlt` assertion against glitches. It latches the final PC and cycle count, and forces the core back into reset with a sticky `timeout` flag if the cycle budget is exceeded. This replaces bench-only halt/timeout logic with synthesizable control, usable on FPGA.

Parameters:
RST_CYCLES, 2, number of cycles `cpu_rst_n` is held low after `start` (legal range 1..255).
CYCLES_LIMIT, 100000, maximum run cycles before timeout (legal range 1..2^CNT_W-1).
HALT_CONFIRM, 2, consecutive sampled edges with `cpu_hlt`=1 needed to accept a halt (legal range 1..15).
CNT_W, 32, width of the cycle counter.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset. Named without an _n suffix because it is active-high.
start  input  1  begin a run. Sampled only in IDLE, DONE and TIMEOUT; ignored while busy.
cpu_hlt  input  1  `hlt` from the cpu core.
cpu_pc  input  16  `pc` (PC+1) from the cpu core.
cpu_rst_n  output  1  active-low reset driven to the cpu core; registered.
busy  output  1  high in RESET, RUN and CONFIRM.
done  output  1  sticky; high in DONE.
timeout  output  1  sticky; high in TIMEOUT.
cycles  output  CNT_W  run-cycle counter; frozen after the run ends.
final_pc  output  16  `cpu_pc` latched at run end.

Behaviour:
- Reset (`rst`=1 at a posedge): state=IDLE, `cpu_rst_n`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0, `final_pc`=0, internal counters=0. Reset overrides everything, including mid-run.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- IDLE: `cpu_rst_n`=0. `start`=1 -> RESET; clear `cycles`, the reset counter, `done` and `timeout`.
- RESET: `cpu_rst_n`=0 for exactly RST_CYCLES edges. On the RST_CYCLES-th edge -> RUN, and `cpu_rst_n` goes to 1 on that same edge.
- `cycles` increments by 1 on every edge whose current state is RUN or CONFIRM, including the edge that leaves that state. It therefore equals the number of edges the core spent released from reset.
- The counter saturates at all-ones and never wraps; this is unreachable given the legal CYCLES_LIMIT range.
- RUN:
  - `cpu_hlt`=1 with HALT_CONFIRM=1 -> DONE.
  - `cpu_hlt`=1 with HALT_CONFIRM>1 -> CONFIRM, confirm count=1.
  - `cpu_hlt`=0 with post-increment `cycles`==CYCLES_LIMIT -> TIMEOUT.
- CONFIRM:
  - `cpu_hlt`=0 -> RUN; confirm count cleared (glitch rejected); the limit check still applies.
  - `cpu_hlt`=1 -> confirm count+1. Reaching HALT_CONFIRM -> DONE.
  - Otherwise, post-increment `cycles`==CYCLES_LIMIT -> TIMEOUT.
- Simultaneous halt completion and limit on the same edge: DONE wins.
- Entry to DONE or TIMEOUT: `final_pc` <= `cpu_pc` sampled on that edge; `cycles` freezes.
- DONE: `cpu_rst_n` stays 1 so the core's architectural state remains inspectable; `done`=1.
- TIMEOUT: `cpu_rst_n`=0 on the entry edge (core forced into reset); `timeout`=1.
- In DONE or TIMEOUT, `start`=1 -> RESET and a fresh run begins (flags and `cycles` cleared on that edge).
- `start` held high continuously: a new run begins immediately after each DONE/TIMEOUT. This is legal.

Decomposition:
- Shared package `cpu_ctrl_pkg`: state encoding constants (IDLE=0, RESET=1, RUN=2, CONFIRM=3, DONE=4, TIMEOUT=5), 3-bit state width, default CYCLES_LIMIT.
- One natural sub-module: `sat_counter` (parameterized width, clear/enable/saturate), used for `cycles`. The reset and confirm counters stay inline.

Test Plan:
1. Apply `rst`, then hold `start` low -> IDLE, all outputs 0, `cpu_rst_n`=0 indefinitely.
2. Defaults (RST_CYCLES=2, HALT_CONFIRM=2). Pulse `start`; the core model raises `hlt` once `cycles`==10 and holds it, with `cpu_pc`=16'h0042 -> `cpu_rst_n` low for exactly 2 edges; DONE two edges after `hlt` is first sampled; `cycles`=12, `final_pc`=16'h0042, `done`=1, `busy`=0.
3. `hlt` single-cycle glitch at `cycles`==5, then real halt at `cycles`==30 -> glitch rejected (CONFIRM->RUN); final `cycles`=32, `done`=1.
4. CYCLES_LIMIT=20, `hlt` never asserted -> TIMEOUT with `cycles`=20, `timeout`=1, `cpu_rst_n` returns to 0, `done`=0.
5. CYCLES_LIMIT=20, `hlt` first sampled at `cycles`==18 (so confirm completes on the 20th edge) -> DONE wins, `done`=1, `timeout`=0, `cycles`=20.
6. Assert `rst` mid-RUN at `cycles`==7 -> next edge: IDLE, `cycles`=0, `cpu_rst_n`=0. Then `start` pulsed in DONE -> RESET, `done` cleared on the same edge.
